// File: rtl/cnn_layer_accel_axi_rd_sched_if.sv
// Bundle for the CNN accelerator AXI read scheduler: client request/data side plus AXI AR/R.
// master = the scheduler, slave = the clients and AXI interconnect it talks to.
interface cnn_layer_accel_axi_rd_sched_if #(
    parameter int unsigned C_NUM_CLIENTS = 8,
    parameter int unsigned C_ADDR_WIDTH  = 29,
    parameter int unsigned C_DATA_WIDTH  = 64
);
    logic [C_NUM_CLIENTS-1:0]              cx_rd_req;
    logic [C_NUM_CLIENTS*C_ADDR_WIDTH-1:0] cx_rd_addr;
    logic [C_NUM_CLIENTS*8-1:0]            cx_rd_len;
    logic [C_NUM_CLIENTS-1:0]              cx_rd_req_ack;
    logic [C_NUM_CLIENTS-1:0]              cx_rd_in_prog;
    logic [C_DATA_WIDTH-1:0]               cx_rd_data;
    logic [C_NUM_CLIENTS-1:0]              cx_rd_data_vld;
    logic [C_NUM_CLIENTS-1:0]              cx_rd_data_rdy;
    logic [C_NUM_CLIENTS-1:0]              cx_rd_cmpl;
    logic                                  rd_err;

    logic                                  axi_arready;
    logic [3:0]                            axi_arid;
    logic [C_ADDR_WIDTH-1:0]               axi_araddr;
    logic [7:0]                            axi_arlen;
    logic [2:0]                            axi_arsize;
    logic [1:0]                            axi_arburst;
    logic [3:0]                            axi_arcache;
    logic                                  axi_arvalid;

    logic [3:0]                            axi_rid;
    logic [1:0]                            axi_rresp;
    logic                                  axi_rvalid;
    logic [C_DATA_WIDTH-1:0]               axi_rdata;
    logic                                  axi_rlast;
    logic                                  axi_rready;

    modport master (
        input  cx_rd_req, cx_rd_addr, cx_rd_len, cx_rd_data_rdy,
        input  axi_arready, axi_rid, axi_rresp, axi_rvalid, axi_rdata, axi_rlast,
        output cx_rd_req_ack, cx_rd_in_prog, cx_rd_data, cx_rd_data_vld, cx_rd_cmpl, rd_err,
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arcache,
        output axi_arvalid, axi_rready
    );

    modport slave (
        output cx_rd_req, cx_rd_addr, cx_rd_len, cx_rd_data_rdy,
        output axi_arready, axi_rid, axi_rresp, axi_rvalid, axi_rdata, axi_rlast,
        input  cx_rd_req_ack, cx_rd_in_prog, cx_rd_data, cx_rd_data_vld, cx_rd_cmpl, rd_err,
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arcache,
        input  axi_arvalid, axi_rready
    );
endinterface

// File: rtl/cnn_layer_accel_axi_rd_sched.sv
// AXI read scheduler: round-robin AR arbitration over clients, tag-pool ID allocation, R steering.
// Define CNN_AXI_RD_SCHED_RESP_CHECK_EN to enable the sticky rd_err flag.
module cnn_layer_accel_axi_rd_sched #(
    parameter int unsigned C_NUM_CLIENTS = 8,
    parameter int unsigned C_NUM_TAGS    = 16,
    parameter int unsigned C_ADDR_WIDTH  = 29,
    parameter int unsigned C_DATA_WIDTH  = 64
) (
    input logic clk,
    input logic rst,
    cnn_layer_accel_axi_rd_sched_if.master bus
);
    localparam int unsigned CW = (C_NUM_CLIENTS > 1) ? $clog2(C_NUM_CLIENTS) : 1;
    localparam int unsigned OW = $clog2(C_NUM_TAGS + 1);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e                    state_q;
    logic [CW-1:0]             ptr_q;
    logic [CW-1:0]             client_q;
    logic [C_ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]                len_q;
    logic [3:0]                id_q;
    logic                      arvalid_q;
    logic [15:0]               tag_vld_q;
    logic [CW-1:0]             tag_owner_q [16];
    logic [OW-1:0]             outst_q [C_NUM_CLIENTS];
    logic [C_NUM_CLIENTS-1:0]  cmpl_q;

    logic                      grant_vld;
    logic [CW-1:0]             grant_idx;
    int                        idx;
    logic                      tag_free;
    logic [3:0]                free_tag;
    logic                      rid_vld;
    logic [CW-1:0]             owner;
    logic [C_NUM_CLIENTS-1:0]  owner_oh;
    logic                      ar_hs;
    logic                      last_hs;
    logic [C_NUM_CLIENTS-1:0]  inc;
    logic [C_NUM_CLIENTS-1:0]  dec;

    // Scan from ptr_q downward so the closest requester at or after the pointer wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = C_NUM_CLIENTS - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % int'(C_NUM_CLIENTS);
            if (bus.cx_rd_req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = CW'(idx);
            end
        end
    end

    always_comb begin
        tag_free = 1'b0;
        free_tag = '0;
        for (int t = C_NUM_TAGS - 1; t >= 0; t--) begin
            if (!tag_vld_q[t]) begin
                tag_free = 1'b1;
                free_tag = 4'(t);
            end
        end
    end

    // Beats to an unallocated ID are accepted and discarded so the R channel never stalls.
    assign rid_vld  = tag_vld_q[bus.axi_rid];
    assign owner    = tag_owner_q[bus.axi_rid];
    assign owner_oh = C_NUM_CLIENTS'(1) << owner;
    assign ar_hs    = arvalid_q & bus.axi_arready;
    assign last_hs  = bus.axi_rvalid & bus.axi_rready & bus.axi_rlast & rid_vld;
    assign inc      = ar_hs ? (C_NUM_CLIENTS'(1) << client_q) : '0;
    assign dec      = last_hs ? owner_oh : '0;

    assign bus.axi_rready     = rid_vld ? bus.cx_rd_data_rdy[owner] : 1'b1;
    assign bus.cx_rd_data_vld = (rid_vld && bus.axi_rvalid) ? owner_oh : '0;
    assign bus.cx_rd_data     = bus.axi_rdata;
    assign bus.cx_rd_req_ack  = inc;
    assign bus.cx_rd_cmpl     = cmpl_q;

    always_comb begin
        for (int i = 0; i < C_NUM_CLIENTS; i++) begin
            bus.cx_rd_in_prog[i] = (outst_q[i] != '0);
        end
    end

    assign bus.axi_arvalid = arvalid_q;
    assign bus.axi_arid    = id_q;
    assign bus.axi_araddr  = addr_q;
    assign bus.axi_arlen   = len_q;
    assign bus.axi_arsize  = 3'd3;
    assign bus.axi_arburst = 2'd1;
    assign bus.axi_arcache = 4'b0011;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            client_q  <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            id_q      <= '0;
            arvalid_q <= 1'b0;
            tag_vld_q <= '0;
            cmpl_q    <= '0;
            for (int t = 0; t < 16; t++) tag_owner_q[t] <= '0;
            for (int i = 0; i < C_NUM_CLIENTS; i++) outst_q[i] <= '0;
        end else begin
            cmpl_q <= dec;
            for (int i = 0; i < C_NUM_CLIENTS; i++) begin
                outst_q[i] <= outst_q[i] + OW'(inc[i]) - OW'(dec[i]);
            end
            if (last_hs) tag_vld_q[bus.axi_rid] <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_vld && tag_free) begin
                        state_q   <= StIssue;
                        arvalid_q <= 1'b1;
                        addr_q    <= bus.cx_rd_addr[int'(grant_idx)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                        len_q     <= bus.cx_rd_len[int'(grant_idx)*8 +: 8];
                        client_q  <= grant_idx;
                        id_q      <= free_tag;
                    end
                end
                StIssue: begin
                    if (bus.axi_arready) begin
                        state_q           <= StIdle;
                        arvalid_q         <= 1'b0;
                        tag_vld_q[id_q]   <= 1'b1;
                        tag_owner_q[id_q] <= client_q;
                        ptr_q <= (int'(client_q) == C_NUM_CLIENTS - 1) ? '0 : client_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef CNN_AXI_RD_SCHED_RESP_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (bus.axi_rvalid && bus.axi_rready && (bus.axi_rresp != 2'b00 || !rid_vld)) begin
            err_q <= 1'b1;
        end
    end
    assign bus.rd_err = err_q;
`else
    logic unused_rresp;
    assign unused_rresp = ^bus.axi_rresp;
    assign bus.rd_err   = 1'b0;
`endif
endmodule

// File: tb/tb_cnn_layer_accel_axi_rd_sched.sv
// Self-checking bench for cnn_layer_accel_axi_rd_sched; expected AR issues kept in a scoreboard queue.
module tb_cnn_layer_accel_axi_rd_sched;
    localparam int unsigned N  = 8;
    localparam int unsigned T  = 16;
    localparam int unsigned AW = 29;
    localparam int unsigned DW = 64;
`ifdef CNN_AXI_RD_SCHED_RESP_CHECK_EN
    localparam bit ExpErr = 1'b1;
`else
    localparam bit ExpErr = 1'b0;
`endif

    typedef struct {
        int            client;
        logic [3:0]    id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } ar_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cnn_layer_accel_axi_rd_sched_if #(.C_NUM_CLIENTS(N), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) bus ();

    cnn_layer_accel_axi_rd_sched #(
        .C_NUM_CLIENTS(N), .C_NUM_TAGS(T), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    ar_exp_t ar_q[$];
    int      n_total = 0;
    int      n_pass  = 0;

    function automatic logic [AW-1:0] addr_of(int i);
        return AW'(32'h0000_2000 + i * 32'h40);
    endfunction

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic set_req(int i, logic [AW-1:0] a, logic [7:0] l);
        bus.cx_rd_addr[i*AW +: AW] = a;
        bus.cx_rd_len[i*8 +: 8]    = l;
        bus.cx_rd_req[i]           = 1'b1;
    endtask

    task automatic do_reset();
        rst                = 1'b0;
        bus.cx_rd_req      = '0;
        bus.cx_rd_addr     = '0;
        bus.cx_rd_len      = '0;
        bus.cx_rd_data_rdy = '1;
        bus.axi_arready    = 1'b0;
        bus.axi_rid        = '0;
        bus.axi_rresp      = '0;
        bus.axi_rvalid     = 1'b0;
        bus.axi_rdata      = '0;
        bus.axi_rlast      = 1'b0;
        ar_q.delete();
        repeat (2) nxt();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_total++;
        if ({bus.axi_arvalid, bus.cx_rd_req_ack, bus.cx_rd_data_vld, bus.cx_rd_cmpl,
             bus.cx_rd_in_prog, bus.rd_err} !== '0)
            $display("FAIL reset_ctrl got arv=%b ack=%h vld=%h cmpl=%h inp=%h err=%b want all 0",
                     bus.axi_arvalid, bus.cx_rd_req_ack, bus.cx_rd_data_vld, bus.cx_rd_cmpl,
                     bus.cx_rd_in_prog, bus.rd_err);
        else n_pass++;
        n_total++;
        if ({bus.axi_arid, bus.axi_araddr, bus.axi_arlen} !== '0)
            $display("FAIL reset_ar got id=%h addr=%h len=%h want 0", bus.axi_arid,
                     bus.axi_araddr, bus.axi_arlen);
        else n_pass++;
        n_total++;
        if (bus.axi_rready !== 1'b1) $display("FAIL reset_rready got %b want 1", bus.axi_rready);
        else n_pass++;
        n_total++;
        if ({bus.axi_arsize, bus.axi_arburst, bus.axi_arcache} !== {3'd3, 2'd1, 4'b0011})
            $display("FAIL ar_const got size=%0d burst=%0d cache=%b want 3 1 0011",
                     bus.axi_arsize, bus.axi_arburst, bus.axi_arcache);
        else n_pass++;
    endtask

    task automatic test_single();
        ar_exp_t e;
        do_reset();
        bus.axi_arready = 1'b1;
        ar_q.push_back('{2, 4'd0, AW'(32'h1000), 8'd3});
        set_req(2, AW'(32'h1000), 8'd3);
        #1;
        n_total++;
        if (bus.axi_arvalid !== 1'b0) $display("FAIL single_lat0 got %b want 0", bus.axi_arvalid);
        else n_pass++;
        nxt(); #1;
        n_total++;
        if (bus.axi_arvalid !== 1'b1) $display("FAIL single_lat1 got %b want 1", bus.axi_arvalid);
        else n_pass++;
        e = ar_q.pop_front();
        n_total++;
        if ({bus.axi_arid, bus.axi_araddr, bus.axi_arlen} !== {e.id, e.addr, e.len})
            $display("FAIL single_ar got id=%h addr=%h len=%h want id=%h addr=%h len=%h",
                     bus.axi_arid, bus.axi_araddr, bus.axi_arlen, e.id, e.addr, e.len);
        else n_pass++;
        n_total++;
        if (bus.cx_rd_req_ack !== (N'(1) << e.client))
            $display("FAIL single_ack got %h want %h", bus.cx_rd_req_ack, N'(1) << e.client);
        else n_pass++;
        bus.cx_rd_req[2] = 1'b0;
        nxt(); #1;
        n_total++;
        if (bus.cx_rd_in_prog !== 8'h04) $display("FAIL single_inprog got %h want 04", bus.cx_rd_in_prog);
        else n_pass++;
        for (int b = 0; b < 4; b++) begin
            bus.axi_rvalid = 1'b1;
            bus.axi_rid    = 4'd0;
            bus.axi_rdata  = 64'hA000 + 64'(b);
            bus.axi_rlast  = (b == 3);
            #1;
            n_total++;
            if ({bus.cx_rd_data_vld, bus.cx_rd_data, bus.axi_rready} !== {8'h04, 64'hA000 + 64'(b), 1'b1})
                $display("FAIL single_beat%0d got vld=%h data=%h rdy=%b want vld=04 data=%h rdy=1",
                         b, bus.cx_rd_data_vld, bus.cx_rd_data, bus.axi_rready, 64'hA000 + 64'(b));
            else n_pass++;
            nxt();
        end
        bus.axi_rvalid = 1'b0;
        bus.axi_rlast  = 1'b0;
        #1;
        n_total++;
        if ({bus.cx_rd_cmpl, bus.cx_rd_in_prog} !== {8'h04, 8'h00})
            $display("FAIL single_cmpl got cmpl=%h inp=%h want cmpl=04 inp=00", bus.cx_rd_cmpl,
                     bus.cx_rd_in_prog);
        else n_pass++;
        nxt(); #1;
        n_total++;
        if (bus.cx_rd_cmpl !== 8'h00) $display("FAIL single_cmpl_pulse got %h want 00", bus.cx_rd_cmpl);
        else n_pass++;
    endtask

    task automatic test_fairness();
        int order[6] = '{0, 1, 7, 0, 1, 7};
        ar_exp_t e;
        int hs = 0, last = 0, gap = 0;
        do_reset();
        bus.axi_arready = 1'b1;
        for (int k = 0; k < 6; k++) ar_q.push_back('{order[k], 4'(k), addr_of(order[k]), 8'd0});
        set_req(0, addr_of(0), 8'd0);
        set_req(1, addr_of(1), 8'd0);
        set_req(7, addr_of(7), 8'd0);
        for (int c = 0; c < 40 && ar_q.size() > 0; c++) begin
            #1;
            if (bus.axi_arvalid && bus.axi_arready) begin
                e = ar_q.pop_front();
                n_total++;
                if ({bus.cx_rd_req_ack, bus.axi_arid, bus.axi_araddr} !==
                    {N'(1) << e.client, e.id, e.addr})
                    $display("FAIL fair_grant%0d got ack=%h id=%h addr=%h want ack=%h id=%h addr=%h",
                             hs, bus.cx_rd_req_ack, bus.axi_arid, bus.axi_araddr,
                             N'(1) << e.client, e.id, e.addr);
                else n_pass++;
                if (hs == 1) gap = c - last;
                last = c;
                hs++;
            end
            nxt();
        end
        n_total++;
        if (ar_q.size() != 0) $display("FAIL fair_timeout got %0d left want 0", ar_q.size());
        else n_pass++;
        n_total++;
        if (gap != 2) $display("FAIL back_to_back_gap got %0d want 2", gap);
        else n_pass++;
        bus.cx_rd_req = '0;
    endtask

    task automatic test_out_of_order();
        ar_exp_t e;
        do_reset();
        bus.axi_arready = 1'b1;
        ar_q.push_back('{3, 4'd0, addr_of(3), 8'd0});
        ar_q.push_back('{5, 4'd1, addr_of(5), 8'd0});
        set_req(3, addr_of(3), 8'd0);
        set_req(5, addr_of(5), 8'd0);
        for (int c = 0; c < 20 && ar_q.size() > 0; c++) begin
            #1;
            if (bus.axi_arvalid && bus.axi_arready) begin
                e = ar_q.pop_front();
                n_total++;
                if ({bus.cx_rd_req_ack, bus.axi_arid} !== {N'(1) << e.client, e.id})
                    $display("FAIL ooo_issue got ack=%h id=%h want ack=%h id=%h", bus.cx_rd_req_ack,
                             bus.axi_arid, N'(1) << e.client, e.id);
                else n_pass++;
                bus.cx_rd_req[e.client] = 1'b0;
            end
            nxt();
        end
        n_total++;
        if (ar_q.size() != 0) $display("FAIL ooo_timeout got %0d left want 0", ar_q.size());
        else n_pass++;
        bus.axi_rvalid = 1'b1;
        bus.axi_rid    = 4'd1;
        #1;
        n_total++;
        if ({bus.cx_rd_data_vld, bus.axi_rready} !== {8'h20, 1'b1})
            $display("FAIL ooo_route got vld=%h rdy=%b want vld=20 rdy=1", bus.cx_rd_data_vld,
                     bus.axi_rready);
        else n_pass++;
        bus.cx_rd_data_rdy[5] = 1'b0;
        #1;
        n_total++;
        if (bus.axi_rready !== 1'b0) $display("FAIL ooo_backpressure got %b want 0", bus.axi_rready);
        else n_pass++;
        nxt();
        bus.cx_rd_data_rdy[5] = 1'b1;
        bus.axi_rlast         = 1'b1;
        nxt();
        bus.axi_rvalid = 1'b0;
        #1;
        n_total++;
        if ({bus.cx_rd_cmpl, bus.cx_rd_in_prog} !== {8'h20, 8'h08})
            $display("FAIL ooo_cmpl5 got cmpl=%h inp=%h want cmpl=20 inp=08", bus.cx_rd_cmpl,
                     bus.cx_rd_in_prog);
        else n_pass++;
        nxt();
        bus.axi_rvalid = 1'b1;
        bus.axi_rid    = 4'd0;
        #1;
        n_total++;
        if (bus.cx_rd_data_vld !== 8'h08) $display("FAIL ooo_route3 got %h want 08", bus.cx_rd_data_vld);
        else n_pass++;
        nxt();
        bus.axi_rvalid = 1'b0;
        bus.axi_rlast  = 1'b0;
        #1;
        n_total++;
        if ({bus.cx_rd_cmpl, bus.cx_rd_in_prog} !== {8'h08, 8'h00})
            $display("FAIL ooo_cmpl3 got cmpl=%h inp=%h want cmpl=08 inp=00", bus.cx_rd_cmpl,
                     bus.cx_rd_in_prog);
        else n_pass++;
    endtask

    task automatic test_exhaustion();
        ar_exp_t e;
        int busy = 0;
        do_reset();
        bus.axi_arready = 1'b1;
        for (int k = 0; k < 16; k++) ar_q.push_back('{6, 4'(k), addr_of(6), 8'd0});
        set_req(6, addr_of(6), 8'd0);
        for (int c = 0; c < 60 && ar_q.size() > 0; c++) begin
            #1;
            if (bus.axi_arvalid && bus.axi_arready) begin
                e = ar_q.pop_front();
                n_total++;
                if (bus.axi_arid !== e.id) $display("FAIL exh_id got %h want %h", bus.axi_arid, e.id);
                else n_pass++;
            end
            nxt();
        end
        n_total++;
        if (ar_q.size() != 0) $display("FAIL exh_timeout got %0d left want 0", ar_q.size());
        else n_pass++;
        repeat (6) begin
            #1;
            if (bus.axi_arvalid) busy++;
            nxt();
        end
        n_total++;
        if (busy != 0) $display("FAIL exh_stall got %0d arvalid cycles want 0", busy);
        else n_pass++;
        ar_q.push_back('{6, 4'd4, addr_of(6), 8'd0});
        bus.axi_rvalid = 1'b1;
        bus.axi_rid    = 4'd4;
        bus.axi_rlast  = 1'b1;
        nxt();
        bus.axi_rvalid = 1'b0;
        bus.axi_rlast  = 1'b0;
        #1;
        n_total++;
        if ({bus.cx_rd_cmpl, bus.axi_arvalid} !== {8'h40, 1'b0})
            $display("FAIL exh_free got cmpl=%h arv=%b want cmpl=40 arv=0", bus.cx_rd_cmpl,
                     bus.axi_arvalid);
        else n_pass++;
        nxt(); #1;
        e = ar_q.pop_front();
        n_total++;
        if ({bus.axi_arvalid, bus.axi_arid} !== {1'b1, e.id})
            $display("FAIL exh_reuse got arv=%b id=%h want arv=1 id=%h", bus.axi_arvalid,
                     bus.axi_arid, e.id);
        else n_pass++;
        bus.cx_rd_req = '0;
    endtask

    task automatic test_error();
        ar_exp_t e;
        do_reset();
        bus.axi_arready = 1'b1;
        ar_q.push_back('{1, 4'd0, addr_of(1), 8'd1});
        set_req(1, addr_of(1), 8'd1);
        for (int c = 0; c < 10 && ar_q.size() > 0; c++) begin
            #1;
            if (bus.axi_arvalid && bus.axi_arready) begin
                e = ar_q.pop_front();
                bus.cx_rd_req[e.client] = 1'b0;
            end
            nxt();
        end
        n_total++;
        if (ar_q.size() != 0) $display("FAIL err_timeout got %0d left want 0", ar_q.size());
        else n_pass++;
        bus.axi_rvalid = 1'b1;
        bus.axi_rid    = 4'd0;
        bus.axi_rresp  = 2'b10;
        nxt();
        bus.axi_rresp = 2'b00;
        bus.axi_rlast = 1'b1;
        #1;
        n_total++;
        if (bus.rd_err !== ExpErr) $display("FAIL err_set got %b want %b", bus.rd_err, ExpErr);
        else n_pass++;
        nxt();
        bus.axi_rvalid = 1'b0;
        bus.axi_rlast  = 1'b0;
        #1;
        n_total++;
        if ({bus.rd_err, bus.cx_rd_cmpl} !== {ExpErr, 8'h02})
            $display("FAIL err_sticky got err=%b cmpl=%h want err=%b cmpl=02", bus.rd_err,
                     bus.cx_rd_cmpl, ExpErr);
        else n_pass++;
        nxt();
        bus.axi_rvalid     = 1'b1;
        bus.axi_rid        = 4'd9;
        bus.cx_rd_data_rdy = '0;
        #1;
        n_total++;
        if ({bus.axi_rready, bus.cx_rd_data_vld} !== {1'b1, 8'h00})
            $display("FAIL invalid_tag got rdy=%b vld=%h want rdy=1 vld=00", bus.axi_rready,
                     bus.cx_rd_data_vld);
        else n_pass++;
        nxt();
        bus.axi_rvalid     = 1'b0;
        bus.cx_rd_data_rdy = '1;
        #1;
        n_total++;
        if (bus.rd_err !== ExpErr) $display("FAIL err_after_invalid got %b want %b", bus.rd_err, ExpErr);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        ar_exp_t e;
        bit seen = 1'b0;
        do_reset();
        bus.axi_arready = 1'b1;
        set_req(4, addr_of(4), 8'd3);
        nxt();
        nxt();
        bus.cx_rd_req[4] = 1'b0;
        bus.axi_rvalid   = 1'b1;
        bus.axi_rid      = 4'd0;
        nxt();
        nxt();
        bus.axi_arready = 1'b0;
        set_req(0, addr_of(0), 8'd0);
        nxt(); #1;
        n_total++;
        if ({bus.axi_arvalid, bus.cx_rd_in_prog} !== {1'b1, 8'h10})
            $display("FAIL arst_pre got arv=%b inp=%h want arv=1 inp=10", bus.axi_arvalid,
                     bus.cx_rd_in_prog);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if ({bus.axi_arvalid, bus.cx_rd_in_prog, bus.cx_rd_data_vld} !== '0)
            $display("FAIL arst_clear got arv=%b inp=%h vld=%h want 0", bus.axi_arvalid,
                     bus.cx_rd_in_prog, bus.cx_rd_data_vld);
        else n_pass++;
        bus.axi_rvalid = 1'b0;
        nxt();
        rst             = 1'b1;
        bus.axi_arready = 1'b1;
        ar_q.push_back('{0, 4'd0, addr_of(0), 8'd0});
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (bus.axi_arvalid) begin
                seen = 1'b1;
                e    = ar_q.pop_front();
                n_total++;
                if ({bus.axi_arid, bus.cx_rd_req_ack} !== {e.id, N'(1) << e.client})
                    $display("FAIL arst_reissue got id=%h ack=%h want id=%h ack=%h", bus.axi_arid,
                             bus.cx_rd_req_ack, e.id, N'(1) << e.client);
                else n_pass++;
            end
            nxt();
        end
        n_total++;
        if (!seen) $display("FAIL arst_timeout got no arvalid want arvalid within 10 cycles");
        else n_pass++;
        bus.cx_rd_req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_out_of_order();
        test_exhaustion();
        test_error();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
